mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single on-chip instruction/data RAM between device 1 (instruction fetch) and device 2 (instruction decoder).
- Owns the RAM-side address, data-in, write-enable and enable signals.
- Grants the RAM to the two devices round-robin, with optional burst lock.
- Returns a one-cycle do_ack per device; read data is taken directly from mem_do in the ack cycle.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width.
- DATA_WIDTH, 32, RAM data width.
- MAX_BURST, 4, maximum consecutive grants to one burst owner before it must yield; must be at least 1.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- devices_mem_en  in  2  per-device request; bit0 = device 1, bit1 = device 2.
- devices_mem_we  in  2  per-device write qualifier, valid while en is high.
- devices_burst_en  in  2  per-device burst request, valid while en is high.
- device_1_mem_addr  in  ADDR_WIDTH  device 1 word address.
- device_1_mem_di  in  DATA_WIDTH  device 1 write data.
- device_2_mem_addr  in  ADDR_WIDTH  device 2 word address.
- device_2_mem_di  in  DATA_WIDTH  device 2 write data.
- devices_do_ack  out  2  one-cycle completion pulse per device.
- mem_en  out  1  RAM enable (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_addr  out  ADDR_WIDTH  RAM address (registered).
- mem_di  out  DATA_WIDTH  RAM write data (registered).
- grant_owner  out  1  index of the current or most recent owner (0 = device 1); debug only.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so device 1 wins the first tie; beat_cnt = 0; lock = 0.
- The asynchronous reset clears mem_en/mem_we immediately, so an in-flight write is not committed if reset asserts before the ACCESS edge.
- Device contract: hold en, we, addr and di stable from assertion until the cycle do_ack is high. On the edge ending that ack cycle, either drop en or present the next request.
- The RAM is synchronous with 1-cycle read latency; mem_do is valid in the ack cycle.
- FSM has three states: IDLE, ACCESS, ACK.
- IDLE:
  - Sample devices_mem_en.
  - None set: stay in IDLE.
  - Otherwise select a winner:
    - If lock=1 and en[last_grant]=1, the locked owner wins.
    - Else if exactly one en is set, that device wins.
    - Else (both set) the device != last_grant wins.
  - On the edge, register mem_addr/mem_di/mem_we from the winner, set mem_en=1, record last_grant = winner, go to ACCESS.
- ACCESS: mem_en=1 for exactly one cycle. The RAM samples on the edge. Then clear mem_en/mem_we and go to ACK.
- ACK:
  - devices_do_ack[last_grant]=1 for exactly this cycle; the other bit stays 0.
  - Unconditionally go to IDLE; en is not re-sampled in ACK.
  - Lock update on this edge:
    - If burst_en[last_grant]=1 and beat_cnt < MAX_BURST-1: lock=1, beat_cnt+1.
    - Else: lock=0, beat_cnt=0.
- Latency: request seen in IDLE at cycle t, ACCESS at t+1, ack at t+2. Maximum throughput is one access per 3 cycles.
- Lock release: if the locked owner has dropped en when IDLE samples, the lock is void and normal arbitration applies. lock and beat_cnt clear on the edge that grants a non-owner.
- Fairness: with both devices continuously requesting and no burst, grants alternate strictly. A burst owner gets at most MAX_BURST consecutive grants, after which the other requester (if any) wins.
- A write returns do_ack in the same cycle position as a read; mem_do is don't-care for writes.
- Requests from the non-granted device are ignored, never dropped, and remain pending until granted.
- mem_addr/mem_di hold their last value outside ACCESS; only mem_en/mem_we are cleared.

Decomposition:
- Shared package holds:
  - FSM state encodings ST_IDLE/ST_ACCESS/ST_ACK (2 bits).
  - Device index constants DEV_IF = 0, DEV_ID = 1.
  - Default ADDR_WIDTH/DATA_WIDTH.
- One natural sub-module: arb_rr2, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant, lock.
  - Outputs: valid, winner.
- Datapath muxing and the FSM stay in mem_arbiter.

Test Plan:
- Single read: device 1 en=1, addr=0x005, RAM[5]=0xDEADBEEF → mem_en high 1 cycle with mem_addr=0x005; do_ack=2'b01 two cycles after the request is sampled; mem_do=0xDEADBEEF in the ack cycle.
- Write then read: device 2 writes 0x12345678 to 0x3FF, then reads 0x3FF → mem_we=1 only in the write's ACCESS cycle; the read acks on bit1 with mem_do=0x12345678.
- Contention: both en held, no burst, for 6 grants → ack order 01,10,01,10,01,10 starting from reset, 3 cycles apart.
- Burst lock: MAX_BURST=4; device 2 burst_en=1 with en held; device 1 en held → four consecutive device-2 acks, then a device-1 ack, then device 2 again.
- Reset mid-access: device 1 write, assert reset during ACCESS before the edge → mem_en/mem_we drop asynchronously; RAM contents unchanged; no do_ack; after release the first tie goes to device 1.
- Idle hold: no en for 20 cycles → mem_en=0 and do_ack=0 throughout; the state remains IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter.
//   - FSM state encoding (2 bits)
//   - device index constants (DEV_IF = instruction fetch, DEV_ID = instruction decoder)
//   - default RAM address/data widths
package mem_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic DEV_IF = 1'b0;
    localparam logic DEV_ID = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Combinational 2-way round-robin picker with burst lock.
// Ports:
//   req[1:0]    per-device request (bit0 = device 1, bit1 = device 2)
//   last_grant  index of the most recent owner
//   lock        most recent owner holds a burst lock
//   valid       at least one request present
//   winner      index of the selected device (meaningful when valid)
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       lock,
    output logic       valid,
    output logic       winner
);

    // A live lock beats round-robin; a tie goes to whoever did not win last.
    always_comb begin
        valid  = |req;
        winner = DEV_IF;
        if (lock && req[last_grant]) begin
            winner = last_grant;
        end else if (req == 2'b01) begin
            winner = DEV_IF;
        end else if (req == 2'b10) begin
            winner = DEV_ID;
        end else if (req == 2'b11) begin
            winner = ~last_grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port instruction/data RAM between instruction
// fetch (device 1) and the instruction decoder (device 2).
// Each access takes IDLE -> ACCESS -> ACK; read data is taken by the device
// straight from the RAM output during its do_ack cycle.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   devices_mem_en/we/burst_en per-device request, write, burst qualifiers
//   device_N_mem_addr/di       per-device address and write data
//   devices_do_ack             one-cycle completion pulse per device
//   mem_en/we/addr/di          registered RAM-side controls
//   grant_owner                current or most recent owner (debug)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            devices_mem_en,
    input  logic [1:0]            devices_mem_we,
    input  logic [1:0]            devices_burst_en,
    input  logic [ADDR_WIDTH-1:0] device_1_mem_addr,
    input  logic [DATA_WIDTH-1:0] device_1_mem_di,
    input  logic [ADDR_WIDTH-1:0] device_2_mem_addr,
    input  logic [DATA_WIDTH-1:0] device_2_mem_di,
    output logic [1:0]            devices_do_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_di,
    output logic                  grant_owner
);

    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    state_t              state;
    logic                last_grant;
    logic                lock;
    logic [BEAT_W-1:0]   beat_cnt;

    logic                pick_valid;
    logic                pick_winner;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_di;
    logic                sel_we;

    arb_rr2 u_arb (
        .req        (devices_mem_en),
        .last_grant (last_grant),
        .lock       (lock),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Request payload of the device the picker selected.
    always_comb begin
        sel_addr = device_1_mem_addr;
        sel_di   = device_1_mem_di;
        sel_we   = devices_mem_we[0];
        if (pick_winner == DEV_ID) begin
            sel_addr = device_2_mem_addr;
            sel_di   = device_2_mem_di;
            sel_we   = devices_mem_we[1];
        end
    end

    // Access sequencer; reset drops mem_en/mem_we at once so an in-flight
    // write never reaches the RAM edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            last_grant     <= DEV_ID;
            lock           <= 1'b0;
            beat_cnt       <= '0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_di         <= '0;
            devices_do_ack <= 2'b00;
            grant_owner    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        mem_en      <= 1'b1;
                        mem_we      <= sel_we;
                        mem_addr    <= sel_addr;
                        mem_di      <= sel_di;
                        last_grant  <= pick_winner;
                        grant_owner <= pick_winner;
                        // Granting anyone but the previous owner ends its burst.
                        if (pick_winner != last_grant) begin
                            lock     <= 1'b0;
                            beat_cnt <= '0;
                        end
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_en         <= 1'b0;
                    mem_we         <= 1'b0;
                    devices_do_ack <= (last_grant == DEV_ID) ? 2'b10 : 2'b01;
                    state          <= ST_ACK;
                end
                ST_ACK: begin
                    devices_do_ack <= 2'b00;
                    // Extend the burst until the owner has had MAX_BURST grants.
                    if (devices_burst_en[last_grant] &&
                        (beat_cnt < BEAT_W'(MAX_BURST - 1))) begin
                        lock     <= 1'b1;
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end else begin
                        lock     <= 1'b0;
                        beat_cnt <= '0;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
